dc_bu_line_ctrl: RTL

//  Ping-pong line-buffer controller for the buffering unit's 2-port memory (1-cycle registered read,

---
 rtl/dc_bu_line_ctrl.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/dc_bu_line_ctrl.sv
// -----------------------------------------------------------------------------
// dc_bu_line_ctrl
//
// Ping-pong line-buffer controller for the buffering unit's 2-port memory.
// Incoming pixel lines are written alternately into two banks of LINE_WIDTH
// words. Each completed line is replayed to a valid/ready output stream. The
// memory has a 1-cycle registered read, and a write always takes priority
// over a read in the same cycle.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid and ready are both high. in_ready depends only on
// registered state. out_valid/out_eol/out_data stay stable while out_valid is
// high and out_ready is low.
//
// Compile-time option:
//   DC_BU_LINE_CTRL_REPEAT_EN  each stored line is read out twice (pass 0 and
//                              pass 1) for 2x vertical upscaling. The bank is
//                              released only after pass 1. When undefined,
//                              every line is read once and no pass counter
//                              exists.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_in_valid/o_in_ready/i_in_data/i_in_eol
//                       input pixel stream; eol marks the last pixel of a line
//   o_out_valid/i_out_ready/o_out_data/o_out_eol
//                       output pixel stream; data comes straight from memory
//   o_mem_ce/we/waddr/wdata/re/raddr, i_mem_rdata
//                       memory control; addr = bank*LINE_WIDTH + column
//   o_lines_buf         number of full banks (0..2)
//   o_dbg_state         {read-side state, write-side state} for observation
// -----------------------------------------------------------------------------
module dc_bu_line_ctrl #(
  parameter int BUFF_ADDR_WIDTH = 10,
  parameter int MEMORY_HEIGHT   = 128,
  parameter int WORD_WIDTH      = 24,
  parameter int LINE_WIDTH      = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [WORD_WIDTH-1:0]      i_in_data,
  input  logic                       i_in_eol,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [WORD_WIDTH-1:0]      o_out_data,
  output logic                       o_out_eol,
  output logic                       o_mem_ce,
  output logic                       o_mem_we,
  output logic [BUFF_ADDR_WIDTH-1:0] o_mem_waddr,
  output logic [WORD_WIDTH-1:0]      o_mem_wdata,
  output logic                       o_mem_re,
  output logic [BUFF_ADDR_WIDTH-1:0] o_mem_raddr,
  input  logic [WORD_WIDTH-1:0]      i_mem_rdata,
  output logic [1:0]                 o_lines_buf,
  output logic [1:0]                 o_dbg_state
);

  localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int LEN_W = COL_W + 1;

  localparam logic [COL_W-1:0]           LAST_COL   = COL_W'(LINE_WIDTH - 1);
  localparam logic [BUFF_ADDR_WIDTH-1:0] BANK1_BASE = BUFF_ADDR_WIDTH'(LINE_WIDTH);

  // Both banks must fit in the memory and be addressable.
  generate
    if ((2 * LINE_WIDTH > MEMORY_HEIGHT) || (MEMORY_HEIGHT > (2 ** BUFF_ADDR_WIDTH))) begin : g_bad_cfg
      $error("dc_bu_line_ctrl: need 2*LINE_WIDTH <= MEMORY_HEIGHT <= 2**BUFF_ADDR_WIDTH");
    end
  endgenerate

  // The state of each side is simply whether the bank it points at is full.
  typedef enum logic {
    W_FILL  = 1'b0,
    W_STALL = 1'b1
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_READ = 1'b1
  } rd_state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]            r_full;
  logic                  r_wr_bank;
  logic                  r_rd_bank;
  logic [COL_W-1:0]      r_wcol;
  logic [COL_W-1:0]      r_rcol;
  logic [1:0][LEN_W-1:0] r_len;
  logic                  r_out_valid;
  logic                  r_out_eol;

  // Next-state values
  logic [1:0]            w_full_nxt;
  logic                  w_wr_bank_nxt;
  logic                  w_rd_bank_nxt;
  logic [COL_W-1:0]      w_wcol_nxt;
  logic [COL_W-1:0]      w_rcol_nxt;
  logic [1:0][LEN_W-1:0] w_len_nxt;
  logic                  w_out_valid_nxt;
  logic                  w_out_eol_nxt;

  // Decoded state and strobes
  wr_state_t             w_wr_state;
  rd_state_t             w_rd_state;
  logic                  w_accept;
  logic                  w_wclose;
  logic                  w_issue;
  logic                  w_rlast;
  logic                  w_final_pass;
  logic [LEN_W-1:0]      w_rlen;

`ifdef DC_BU_LINE_CTRL_REPEAT_EN
  logic                  r_pass;
  logic                  w_pass_nxt;
  assign w_final_pass = r_pass;
`else
  assign w_final_pass = 1'b1;
`endif

  assign w_wr_state = r_full[r_wr_bank] ? W_STALL : W_FILL;
  assign w_rd_state = r_full[r_rd_bank] ? R_READ  : R_IDLE;
  assign w_rlen     = r_len[r_rd_bank];
  assign w_rlast    = ({1'b0, r_rcol} == (w_rlen - LEN_W'(1)));

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_accept        = 1'b0;
    w_wclose        = 1'b0;
    w_issue         = 1'b0;
    w_full_nxt      = r_full;
    w_wr_bank_nxt   = r_wr_bank;
    w_rd_bank_nxt   = r_rd_bank;
    w_wcol_nxt      = r_wcol;
    w_rcol_nxt      = r_rcol;
    w_len_nxt       = r_len;
    w_out_valid_nxt = r_out_valid;
    w_out_eol_nxt   = r_out_eol;
`ifdef DC_BU_LINE_CTRL_REPEAT_EN
    w_pass_nxt      = r_pass;
`endif

    // Write side
    case (w_wr_state)
      W_FILL: begin
        w_accept = i_in_valid;
        if (w_accept) begin
          w_wclose = i_in_eol || (r_wcol == LAST_COL);
          if (w_wclose) begin
            w_full_nxt[r_wr_bank] = 1'b1;
            w_len_nxt[r_wr_bank]  = {1'b0, r_wcol} + LEN_W'(1);
            w_wr_bank_nxt         = ~r_wr_bank;
            w_wcol_nxt            = '0;
          end else begin
            w_wcol_nxt = r_wcol + COL_W'(1);
          end
        end
      end
      W_STALL: ;
      default: ;
    endcase

    // Read side: a write cycle blocks the read, and a read is only issued
    // when the output register is empty or is being consumed this cycle.
    case (w_rd_state)
      R_READ: begin
        w_issue = !w_accept && (!r_out_valid || i_out_ready);
        if (w_issue && w_rlast) begin
          w_rcol_nxt = '0;
          if (w_final_pass) begin
            // Release the bank; never the one being closed this cycle since
            // that one was still empty.
            w_full_nxt[r_rd_bank] = 1'b0;
            w_rd_bank_nxt         = ~r_rd_bank;
          end
`ifdef DC_BU_LINE_CTRL_REPEAT_EN
          w_pass_nxt = ~r_pass;
`endif
        end else if (w_issue) begin
          w_rcol_nxt = r_rcol + COL_W'(1);
        end
      end
      R_IDLE: ;
      default: ;
    endcase

    // Output register tracks the memory's 1-cycle read latency.
    if (w_issue) begin
      w_out_valid_nxt = 1'b1;
      w_out_eol_nxt   = w_rlast;
    end else if (i_out_ready) begin
      w_out_valid_nxt = 1'b0;
      w_out_eol_nxt   = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full      <= '0;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wcol      <= '0;
      r_rcol      <= '0;
      r_len       <= '0;
      r_out_valid <= 1'b0;
      r_out_eol   <= 1'b0;
`ifdef DC_BU_LINE_CTRL_REPEAT_EN
      r_pass      <= 1'b0;
`endif
    end else begin
      r_full      <= w_full_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      r_rd_bank   <= w_rd_bank_nxt;
      r_wcol      <= w_wcol_nxt;
      r_rcol      <= w_rcol_nxt;
      r_len       <= w_len_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_eol   <= w_out_eol_nxt;
`ifdef DC_BU_LINE_CTRL_REPEAT_EN
      r_pass      <= w_pass_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_in_ready  = (w_wr_state == W_FILL);
  assign o_out_valid = r_out_valid;
  assign o_out_eol   = r_out_eol;
  assign o_out_data  = i_mem_rdata;

  assign o_mem_we    = w_accept;
  assign o_mem_re    = w_issue;
  assign o_mem_ce    = w_accept | w_issue;
  assign o_mem_wdata = i_in_data;
  assign o_mem_waddr = (r_wr_bank ? BANK1_BASE : '0) + BUFF_ADDR_WIDTH'(r_wcol);
  assign o_mem_raddr = (r_rd_bank ? BANK1_BASE : '0) + BUFF_ADDR_WIDTH'(r_rcol);

  assign o_lines_buf = {1'b0, r_full[0]} + {1'b0, r_full[1]};
  assign o_dbg_state = {w_rd_state, w_wr_state};

endmodule
